// File: rtl/outer_product_sched.sv
// Outer-product scheduler: collects N (A,B) element pairs, then streams the
// N*N products A[i]*B[j] in row-major order through a shared multiplier,
// honouring downstream backpressure.
module outer_product_sched #(
  parameter int unsigned N      = 16,
  parameter int unsigned DW_IN  = 4,
  parameter int unsigned DW_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_matrix_A,
  input  logic [DW_IN-1:0]  in_matrix_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_OUT-1:0] out_matrix,
  output logic              out_last,
  output logic              busy
);

  // N is assumed to be a power of two so k splits cleanly into {i, j}.
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned KW = 2 * CW;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e           state;
  logic [CW-1:0]    in_cnt;
  logic [KW-1:0]    k;
  logic [DW_IN-1:0] a_buf [N];
  logic [DW_IN-1:0] b_buf [N];

  logic              in_acc;
  logic              out_adv;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [DW_OUT-1:0] prod;

  // Handshake qualifiers and the shared multiplier, indexed by the product counter.
  always_comb begin
    in_acc  = in_valid && in_ready;
    out_adv = !out_valid || out_ready;
    row     = k[KW-1:CW];
    col     = k[CW-1:0];
    prod    = DW_OUT'(a_buf[row]) * DW_OUT'(b_buf[col]);
  end

  // Operand buffers; no reset since a new frame always overwrites every entry.
  // in_ready is low in RUN, so RUN-time pairs never reach the buffers.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      a_buf[in_cnt] <= in_matrix_A;
      b_buf[in_cnt] <= in_matrix_B;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      in_cnt     <= '0;
      k          <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_matrix <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_acc) begin
            in_cnt <= in_cnt + CW'(1);
            state  <= StLoad;
            busy   <= 1'b1;
          end
        end
        StLoad: begin
          if (in_acc) begin
            if (in_cnt == CW'(N - 1)) begin
              in_cnt   <= '0;
              k        <= '0;
              in_ready <= 1'b0;
              state    <= StRun;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        StRun: begin
          // Everything is frozen while a product waits for out_ready.
          if (out_adv) begin
            if (out_valid && out_last) begin
              out_valid  <= 1'b0;
              out_matrix <= '0;
              out_last   <= 1'b0;
              k          <= '0;
              in_ready   <= 1'b1;
              busy       <= 1'b0;
              state      <= StIdle;
            end else begin
              out_valid  <= 1'b1;
              out_matrix <= prod;
              out_last   <= (k == KW'(N * N - 1));
              k          <= k + KW'(1);
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/outer_product_sched.md
# outer_product_sched

Single-clock controller that sequences a shared 4x4-bit multiplier to produce the 16x16 outer product C[i][j] = A[i]*B[j]. It sits on the computation side of the matrix pipeline. Upstream, it collects 16 (A,B) element pairs through a valid/ready handshake. Downstream, it streams the 256 products in row-major order through a valid/ready handshake, so a full CDC FIFO can stall it.

## Interface
- N, 16, vector length (elements per frame); products per frame = N*N
- DW_IN, 4, element width
- DW_OUT, 8, product width (2*DW_IN)
- clk  input  1  block clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk
- in_valid  input  1  element pair present on in_matrix_A/in_matrix_B
- in_ready  output  1  block accepts a pair this cycle
- in_matrix_A  input  DW_IN  element A[i], unsigned
- in_matrix_B  input  DW_IN  element B[i], unsigned
- out_valid  output  1  out_matrix holds a valid product
- out_ready  input  1  downstream accepts product this cycle
- out_matrix  output  DW_OUT  product A[i]*B[j], unsigned
- out_last  output  1  high with product index N*N-1 (C[15][15])
- busy  output  1  high in LOAD and RUN

## Operation
- Storage: two N x DW_IN register files, A_buf and B_buf. Input counter in_cnt is clog2(N) bits. Product counter k is clog2(N*N) bits, with i = k[7:4] and j = k[3:0].
- Input acceptance: a pair is accepted on any edge where in_valid && in_ready. The pair is written to A_buf[in_cnt] and B_buf[in_cnt], then in_cnt increments.
- States:
  - IDLE: in_ready=1, out_valid=0. An accepted pair moves the FSM to LOAD with in_cnt=1.
  - LOAD: in_ready=1. Gaps in in_valid are allowed and the FSM holds state. When the N-th pair is accepted (in_cnt==N-1), in_cnt wraps to 0, k clears to 0 and the FSM moves to RUN.
  - RUN: in_ready=0, and in_valid is ignored with no buffer write. The output register loads A_buf[i]*B_buf[j] when it is empty, or when out_valid && out_ready; k increments on each load. On the handshake of k=N*N-1, out_valid clears and the FSM returns to IDLE.
- Output hold: while out_valid && !out_ready, out_matrix, out_last and k are frozen.
- out_matrix is driven to 0 whenever out_valid=0.
- Arithmetic: full-width unsigned multiply. The maximum 15*15=225 (8'hE1) fits DW_OUT, so there is no truncation.
- busy = (state != IDLE).
- Reset mid-operation: the FSM goes to IDLE, in_cnt=0, k=0, and all outputs take their reset values. Buffer contents are don't-care and are not cleared. The next frame starts fresh.

## Timing
- Reset values: in_ready=1, out_valid=0, out_matrix=0, out_last=0, busy=0.
- Latency:
  - The 16th pair is accepted at edge E0, and the FSM is in RUN after E0.
  - Product C[0][0] is registered at E1, so out_valid is high after E1, one cycle after the last input.
- Throughput:
  - With out_ready held high, one product per cycle, and the 256 products occupy 256 consecutive cycles.
  - Total frame time is 16 input cycles, 1 turnaround cycle and 256 output cycles.
- Return to IDLE: after the final handshake edge, out_valid=0 and in_ready=1 in the same cycle. A new frame's first pair can be accepted on the next edge.
- in_ready and out_valid are never high in the same cycle.
- Stalls: out_ready low for S cycles adds exactly S cycles to the frame, with no lost or duplicated product.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs. Required after release: in_ready=1, out_valid=0, out_matrix=0, busy=0.
- Basic frame: A[i]=i, B[i]=15-i, in_valid contiguous, out_ready=1.
  - out_valid rises 1 cycle after the 16th input.
  - 256 consecutive products: C[0][0]=0, C[1][0]=15, C[15][0]=225, C[15][15]=0.
  - out_last is high only on the 256th product.
- Max operands: all A=B=15. All 256 outputs are 8'hE1 and there is no overflow.
- Backpressure: random frame with out_ready toggling 1,0,0,1 repeatedly.
  - Product sequence matches the row-major golden model.
  - out_matrix is stable while stalled.
  - Frame length is 257 plus the number of stall cycles.
- Input gaps and illegal input: 3-cycle in_valid gaps during LOAD, then in_valid=1 with A=B=7 during RUN.
  - Products match the loaded frame only; the RUN-time pairs are ignored.
  - in_ready=0 throughout RUN.
- Reset mid-RUN: assert rst after 100 products. Then send a new frame, back-to-back, with a 1-cycle idle gap before the following frame.
  - Outputs go to reset values on the next edge.
  - The new frame completes correctly.
  - No in_valid/out_valid overlap at any time.
